// File: rtl/lock_seq_ctrl.sv
// lock_seq_ctrl: sequencing controller for a 4-key combination lock.
//
// Converts raw key levels X0..X3 into discrete press events, compares them
// against a stored CODE_LEN-digit code (2 bits per digit, first digit in the
// LSBs) and drives the lock. Consecutive failed attempts are counted, and
// reaching MAX_FAIL triggers a lockout period. An opened lock relocks itself
// after OPEN_CYC cycles.
//
// Optional feature: define LOCK_PROG_EN to enable code reprogramming (PROG
// state, staging register, prog_done). Without it the code is the constant
// DEFAULT_CODE, prog_req is ignored and prog_done is tied low.
//
// Ports:
//   clk        rising-edge clock
//   clean      asynchronous active-low reset
//   X0..X3     key levels, synchronous to clk
//   prog_req   request to enter programming (honoured only while open)
//   lock       1 = locked, 0 = open
//   err        one-cycle pulse on a failed attempt or aborted programming
//   lockout    high while failed-attempt lockout is active
//   fail_cnt   consecutive failed attempts (saturates at MAX_FAIL)
//   prog_done  one-cycle pulse when a new code has been stored

module lock_seq_ctrl #(
  parameter int unsigned           CODE_LEN     = 4,
  parameter logic [2*CODE_LEN-1:0] DEFAULT_CODE = 8'hC2,
  parameter int unsigned           MAX_FAIL     = 3,
  parameter int unsigned           LOCKOUT_CYC  = 16,
  parameter int unsigned           OPEN_CYC     = 8
) (
  input  logic       clk,
  input  logic       clean,
  input  logic       X0,
  input  logic       X1,
  input  logic       X2,
  input  logic       X3,
  input  logic       prog_req,
  output logic       lock,
  output logic       err,
  output logic       lockout,
  output logic [2:0] fail_cnt,
  output logic       prog_done
);

  localparam int unsigned TMax = (LOCKOUT_CYC > OPEN_CYC) ? LOCKOUT_CYC : OPEN_CYC;
  localparam int unsigned TW   = (TMax > 1) ? $clog2(TMax) : 1;
  localparam int unsigned PW   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

  localparam logic [TW-1:0] OpenLoad = TW'(OPEN_CYC - 1);
  localparam logic [TW-1:0] LockLoad = TW'(LOCKOUT_CYC - 1);
  localparam logic [PW-1:0] LastPos  = PW'(CODE_LEN - 1);
  localparam logic [2:0]    MaxFail  = 3'(MAX_FAIL);

  typedef enum logic [2:0] {
    StIdle,
    StEntry,
    StOpen,
    StLockout
`ifdef LOCK_PROG_EN
    , StProg
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic            mis_q, mis_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      fail_q, fail_d;
  logic [3:0]      k_prev_q;
  logic            err_q, err_d;
  logic            done_q, done_d;

  logic [3:0]      k;
  logic            k_idle;
  logic            multi;
  logic            press;
  logic            bad;
  logic [1:0]      digit;
  logic [1:0]      code_digit;
  logic [2:0]      fail_inc;
  logic [2*CODE_LEN-1:0] code;

`ifdef LOCK_PROG_EN
  logic [2*CODE_LEN-1:0] code_q, code_d;
  logic [2*CODE_LEN-1:0] stage_q, stage_d;
  assign code = code_q;
`else
  logic unused_prog_req;
  assign unused_prog_req = prog_req;
  assign code = DEFAULT_CODE;
`endif

  // Events only fire from an all-released history, so held keys, added keys
  // and releases never produce a second event.
  assign k      = {X3, X2, X1, X0};
  assign k_idle = (k_prev_q == 4'b0000);
  assign multi  = ((k & (k - 4'd1)) != 4'b0000);
  assign press  = k_idle && (k != 4'b0000) && !multi;
  assign bad    = k_idle && multi;
  assign digit  = {k[3] | k[2], k[3] | k[1]};

  assign fail_inc = (fail_q >= MaxFail) ? MaxFail : fail_q + 3'd1;

  always_comb begin
    code_digit = code[1:0];
    for (int i = 0; i < int'(CODE_LEN); i++) begin
      if (pos_q == PW'(i)) code_digit = code[2*i +: 2];
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    mis_d   = mis_q;
    timer_d = timer_q;
    fail_d  = fail_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
`ifdef LOCK_PROG_EN
    code_d  = code_q;
    stage_d = stage_q;
`endif
    unique case (state_q)
      StIdle, StEntry: begin
        if (bad || (press && pos_q == LastPos && (mis_q || digit != code_digit))) begin
          err_d  = 1'b1;
          fail_d = fail_inc;
          pos_d  = '0;
          mis_d  = 1'b0;
          if (fail_inc == MaxFail) begin
            state_d = StLockout;
            timer_d = LockLoad;
          end else begin
            state_d = StIdle;
          end
        end else if (press && pos_q == LastPos) begin
          state_d = StOpen;
          timer_d = OpenLoad;
          fail_d  = '0;
          pos_d   = '0;
          mis_d   = 1'b0;
        end else if (press) begin
          // No early rejection: a wrong digit is only remembered.
          state_d = StEntry;
          pos_d   = pos_q + PW'(1);
          mis_d   = mis_q | (digit != code_digit);
        end
      end
      StOpen: begin
`ifdef LOCK_PROG_EN
        if (prog_req) begin
          state_d = StProg;
          pos_d   = '0;
          stage_d = code_q;
        end else
`endif
        if (timer_q == '0) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      StLockout: begin
        if (timer_q == '0) begin
          state_d = StIdle;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
`ifdef LOCK_PROG_EN
      StProg: begin
        if (bad) begin
          // Staging contents are dropped; code_q was never touched.
          err_d   = 1'b1;
          state_d = StIdle;
          pos_d   = '0;
        end else if (press) begin
          for (int i = 0; i < int'(CODE_LEN); i++) begin
            if (pos_q == PW'(i)) stage_d[2*i +: 2] = digit;
          end
          if (pos_q == LastPos) begin
            code_d  = stage_d;
            done_d  = 1'b1;
            state_d = StIdle;
            pos_d   = '0;
          end else begin
            pos_d = pos_q + PW'(1);
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clean) begin
    if (!clean) begin
      state_q  <= StIdle;
      pos_q    <= '0;
      mis_q    <= 1'b0;
      timer_q  <= '0;
      fail_q   <= '0;
      k_prev_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
`ifdef LOCK_PROG_EN
      code_q   <= DEFAULT_CODE;
      stage_q  <= DEFAULT_CODE;
`endif
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      mis_q    <= mis_d;
      timer_q  <= timer_d;
      fail_q   <= fail_d;
      k_prev_q <= k;
      err_q    <= err_d;
      done_q   <= done_d;
`ifdef LOCK_PROG_EN
      code_q   <= code_d;
      stage_q  <= stage_d;
`endif
    end
  end

`ifdef LOCK_PROG_EN
  assign lock      = !((state_q == StOpen) || (state_q == StProg));
  assign prog_done = done_q;
`else
  logic unused_done;
  assign unused_done = done_q;
  assign lock      = (state_q != StOpen);
  assign prog_done = 1'b0;
`endif
  assign lockout  = (state_q == StLockout);
  assign err      = err_q;
  assign fail_cnt = fail_q;

endmodule

// File: doc/lock_seq_ctrl.md
Name: lock_seq_ctrl

Overview:
- Sequencing controller for the 4-key combination lock.
- Turns the raw X0..X3 key levels into discrete key-press events and checks them against a stored CODE_LEN-digit code.
- Drives `lock`, limits failed attempts with a lockout period, relocks automatically after an open window, and optionally allows the code to be reprogrammed.

Parameters:
- CODE_LEN, 4: number of digits per code, 1..8.
- DEFAULT_CODE, 8'hC2: reset code, 2 bits per digit, first digit at [1:0]. Default sequence is X2, X0, X0, X3.
- MAX_FAIL, 3: consecutive failed attempts that trigger lockout, 1..7.
- LOCKOUT_CYC, 16: lockout duration in clk cycles, >=1.
- OPEN_CYC, 8: unlocked duration in clk cycles, >=1.

Ports:
- clk  in  1  rising-edge clock.
- clean  in  1  asynchronous active-low reset.
- X0  in  1  key 0 level, synchronous to clk.
- X1  in  1  key 1 level.
- X2  in  1  key 2 level.
- X3  in  1  key 3 level.
- prog_req  in  1  request to enter code programming (only honoured in OPEN).
- lock  out  1  1 = locked, 0 = open.
- err  out  1  one-cycle pulse on a failed attempt.
- lockout  out  1  high while in LOCKOUT.
- fail_cnt  out  3  consecutive failed attempts.
- prog_done  out  1  one-cycle pulse when a new code is stored.

Behaviour:
- Reset (clean=0, asynchronous): state=IDLE, lock=1, err=0, lockout=0, fail_cnt=0, prog_done=0, digit position=0, mismatch flag=0, code register=DEFAULT_CODE, key history=0000. Reset asserted mid-operation aborts everything immediately.
- Key sampling: k={X3,X2,X1,X0} is registered every cycle as k_prev.
  - Press event when k_prev==0 and k is one-hot; the digit is the index of the set bit.
  - Bad press when k_prev==0 and k has two or more bits set.
  - Any other change (held key, key added while another is held, release) is ignored.
  - Consecutive equal digits therefore need an all-zero cycle between them.
  - Event decode is combinational on k and k_prev; the resulting state update happens at the same clk edge.
- IDLE / ENTRY (lock=1):
  - Each press compares its digit with code[2*pos+1:2*pos]. A mismatch sets the sticky mismatch flag. pos increments; state is ENTRY while 0<pos<CODE_LEN.
  - No early rejection: a wrong digit does not end the attempt before the CODE_LEN-th press.
  - A bad press ends the attempt immediately as a failure.
  - On the CODE_LEN-th press with no mismatch: go to OPEN, lock=0 on the next cycle, fail_cnt=0, timer=OPEN_CYC-1.
  - On a failure: err=1 for one cycle, fail_cnt+1, pos=0, mismatch cleared.
    - If the new fail_cnt==MAX_FAIL: go to LOCKOUT, timer=LOCKOUT_CYC-1.
    - Otherwise: go to IDLE.
- OPEN (lock=0):
  - Key presses are ignored.
  - Timer decrements each cycle. At timer==0 and no prog_req: go to IDLE, lock=1. OPEN therefore lasts exactly OPEN_CYC cycles.
  - prog_req=1 in any OPEN cycle (including the last) has priority over the timeout: go to PROG (only with the optional feature; otherwise prog_req is ignored).
- LOCKOUT (lock=1, lockout=1):
  - All presses and prog_req are ignored.
  - Lasts LOCKOUT_CYC cycles, then go to IDLE with fail_cnt=0 and lockout=0.
- PROG (lock=0):
  - Each valid press writes its digit into code[pos] and increments pos.
  - After the CODE_LEN-th digit: prog_done=1 for one cycle, go to IDLE, lock=1, pos=0.
  - A bad press aborts: the old code is restored in full (staging register, committed only on completion), err pulses, go to IDLE. fail_cnt is unchanged.
  - No timeout in PROG.
- fail_cnt saturates at MAX_FAIL and never wraps.
- err and prog_done are never high in the same cycle.

Optional Feature:
- Macro LOCK_PROG_EN.
- Defined: PROG state, staging register and prog_done are implemented as described above.
- Undefined: code is the constant DEFAULT_CODE, prog_req is ignored, prog_done is tied to 0, and the PROG state does not exist.

Test Plan:
- Reset, then press X2, X0, (release), X0, X3 with an all-zero cycle between presses -> lock falls to 0 the cycle after the X3 press, stays 0 for 8 cycles, then returns to 1; err never asserts.
- Sequence X2, X1, X0, X3 -> no reaction before the 4th press; err pulses once after the 4th press, fail_cnt=1, lock stays 1.
- Three wrong 4-digit attempts -> fail_cnt=3, lockout=1 for 16 cycles. A correct code entered during lockout is ignored. Afterwards fail_cnt=0 and a correct code opens the lock.
- Press X0 and X2 together from idle -> immediate err pulse, fail_cnt=1, pos back to 0. Holding X2 for 5 cycles counts as a single press.
- With LOCK_PROG_EN: open the lock, pulse prog_req, press X1, X1, X3, X0 -> prog_done pulse, lock=1. The old code now fails; X1, X1, X3, X0 opens.
- Assert clean low for one cycle mid-ENTRY and mid-OPEN -> lock=1 and fail_cnt=0 immediately. After LOCK_PROG_EN reprogramming, reset restores 8'hC2.
